hamming_counter: RTL and testbench



---
 rtl/hamming_counter_pkg.sv | 18 +
 rtl/hamming_encoder.sv | 44 ++++
 rtl/hamming_counter.sv | 33 +++
 tb/tb_hamming_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hamming_counter_pkg.sv
// hamming_counter_pkg: shared widths, codeword layout and types for the
// Hamming-encoded counter. Bit 0 of the codeword depends on the build macro
// HAMMING_COUNTER_SECDED_EN. Positions 1..15 are the same in both builds.
package hamming_counter_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;
  localparam int PAR_N  = 4;

  // Parity bits sit at the power-of-two positions.
  localparam int PARITY_POS [PAR_N] = '{1, 2, 4, 8};

  // d0..d10 fill the remaining positions in ascending order.
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef logic [CODE_W-1:0] codeword_t;

endpackage

// File: rtl/hamming_encoder.sv
// hamming_encoder: combinational (15,11) Hamming encode of 11 data bits.
// With HAMMING_COUNTER_SECDED_EN defined, bit 0 carries the overall parity,
// which makes a SECDED (16,11) word. Without it, bit 0 is tied low.
module hamming_encoder
  import hamming_counter_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output codeword_t         o_code
);

  logic [PAR_N-1:0] w_par;
  codeword_t        w_code;

  // Each parity bit covers the data positions whose index has that bit set.
  always_comb begin
    w_par = '0;
    for (int j = 0; j < PAR_N; j++) begin
      for (int i = 0; i < DATA_W; i++) begin
        if ((DATA_POS[i] & PARITY_POS[j]) != 0) begin
          w_par[j] ^= i_data[i];
        end
      end
    end
  end

  // Place the data and parity bits, then fill position 0.
  always_comb begin
    w_code = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_code[DATA_POS[i]] = i_data[i];
    end
    for (int j = 0; j < PAR_N; j++) begin
      w_code[PARITY_POS[j]] = w_par[j];
    end
`ifdef HAMMING_COUNTER_SECDED_EN
    w_code[0] = ^w_code[CODE_W-1:1];
`else
    w_code[0] = 1'b0;
`endif
  end

  assign o_code = w_code;

endmodule

// File: rtl/hamming_counter.sv
// hamming_counter: free-running 11-bit up-counter. Its value appears on
// counter as a Hamming codeword. Bit 0 is the overall parity when
// HAMMING_COUNTER_SECDED_EN is defined and 0 otherwise. The output is a
// purely combinational encode of the count register.
module hamming_counter
  import hamming_counter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [CODE_W-1:0] counter
);

  logic [DATA_W-1:0] r_cnt;
  codeword_t         w_code;

  // Count register: reset takes priority over enable, and 2047 wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + DATA_W'(1);
    end
  end

  hamming_encoder u_enc (
    .i_data (r_cnt),
    .o_code (w_code)
  );

  assign counter = w_code;

endmodule

// File: tb/tb_hamming_counter.sv
// tb_hamming_counter: directed bench for hamming_counter. It runs in either
// build: bit 0 of every expected word follows HAMMING_COUNTER_SECDED_EN.
module tb_hamming_counter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] counter;

  int n_vec;
  int n_err;

  hamming_counter dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .counter (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected words are written for the SECDED build. Bit 0 is cleared otherwise.
  function automatic logic [15:0] adj(input logic [15:0] v);
`ifdef HAMMING_COUNTER_SECDED_EN
    return v;
`else
    return {v[15:1], 1'b0};
`endif
  endfunction

  // Apply n edges with the current inputs and sample 1 ns after the last edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    tick(1);
    n_vec++;
    if (counter !== 16'h0000) begin
      n_err++;
      $display("FAIL reset: got %h want %h", counter, 16'h0000);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      n_vec++;
      if (counter !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h want %h", k, counter, 16'h0000);
      end
    end
  endtask

  task automatic test_count();
    enable = 1'b1;
    tick(1);
    n_vec++;
    if (counter !== adj(16'h000F)) begin
      n_err++;
      $display("FAIL count1: got %h want %h", counter, adj(16'h000F));
    end
    tick(1);
    n_vec++;
    if (counter !== adj(16'h0033)) begin
      n_err++;
      $display("FAIL count2: got %h want %h", counter, adj(16'h0033));
    end
    tick(8);
    n_vec++;
    if (counter !== adj(16'h00A5)) begin
      n_err++;
      $display("FAIL count10: got %h want %h", counter, adj(16'h00A5));
    end
  endtask

  task automatic test_hold_resume();
    enable = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      n_vec++;
      if (counter !== adj(16'h00A5)) begin
        n_err++;
        $display("FAIL hold[%0d]: got %h want %h", k, counter, adj(16'h00A5));
      end
    end
    enable = 1'b1;
    tick(5);
    n_vec++;
    if (counter !== adj(16'h00FF)) begin
      n_err++;
      $display("FAIL resume15: got %h want %h", counter, adj(16'h00FF));
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; enable = 1'b1;
    tick(1);
    n_vec++;
    if (counter !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_priority: got %h want %h", counter, 16'h0000);
    end
    rst = 1'b0;
    tick(1);
    n_vec++;
    if (counter !== adj(16'h000F)) begin
      n_err++;
      $display("FAIL after_rst_count1: got %h want %h", counter, adj(16'h000F));
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; enable = 1'b0;
    tick(1);
    rst = 1'b0; enable = 1'b1;
    tick(2047);
    n_vec++;
    if (counter !== adj(16'hFFFF)) begin
      n_err++;
      $display("FAIL count2047: got %h want %h", counter, adj(16'hFFFF));
    end
    tick(1);
    n_vec++;
    if (counter !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap: got %h want %h", counter, 16'h0000);
    end
    enable = 1'b0;
  endtask

  // Decode every count from the bus and check the code properties.
  task automatic test_code_property();
    int          dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [10:0] data;
    logic [3:0]  syn;
    rst = 1'b1; enable = 1'b0;
    tick(1);
    rst = 1'b0; enable = 1'b1;
    for (int c = 0; c < 2048; c++) begin
      for (int i = 0; i < 11; i++) data[i] = counter[dpos[i]];
      syn = 4'd0;
      for (int p = 1; p < 16; p++) if (counter[p]) syn ^= 4'(p);
      n_vec++;
      if (data !== 11'(c)) begin
        n_err++;
        $display("FAIL data[%0d]: got %h want %h", c, data, 11'(c));
      end
      n_vec++;
      if (syn !== 4'd0) begin
        n_err++;
        $display("FAIL syndrome[%0d]: got %h want 0 (word %h)", c, syn, counter);
      end
      n_vec++;
`ifdef HAMMING_COUNTER_SECDED_EN
      if ((^counter) !== 1'b0) begin
        n_err++;
        $display("FAIL even_parity[%0d]: got parity %b want 0 (word %h)", c, ^counter, counter);
      end
`else
      if (counter[0] !== 1'b0) begin
        n_err++;
        $display("FAIL bit0_zero[%0d]: got %b want 0 (word %h)", c, counter[0], counter);
      end
`endif
      tick(1);
    end
    enable = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    enable = 1'b0;
    #2;
    test_reset();
    test_count();
    test_hold_resume();
    test_reset_priority();
    test_wrap();
    test_code_property();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
